// File: rtl/gc_operand_fetch.sv
// Operand fetch stage: waits for both input wire labels to be written, reads them
// from the dual-port label RAM, and hands labels plus descriptor to the garbling core.
module gc_operand_fetch #(
    parameter int S        = 13,
    parameter int K        = 128,
    parameter int T        = 2,
    parameter int RD_LAT   = 1,
    parameter int WAIT_MAX = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         gate_valid,
    output logic         gate_ready,
    input  logic [S-1:0] gate_addr_a,
    input  logic [S-1:0] gate_addr_b,
    input  logic         gate_unary,
    input  logic [S-1:0] gate_out_addr,
    input  logic [T-1:0] gate_type,
    output logic         rd_req_0,
    output logic         rd_req_1,
    output logic [S-1:0] rd_addr_0,
    output logic [S-1:0] rd_addr_1,
    input  logic         rd_data_ready_0,
    input  logic         rd_data_ready_1,
    input  logic         stall_rd,
    input  logic [K-1:0] rd_data_0,
    input  logic [K-1:0] rd_data_1,
    output logic         op_valid,
    input  logic         op_ready,
    output logic [K-1:0] op_label_a,
    output logic [K-1:0] op_label_b,
    output logic [S-1:0] op_out_addr,
    output logic [T-1:0] op_type,
    output logic         op_unary,
    output logic         dep_hang
);

    localparam int CW_RAW = $clog2(WAIT_MAX + 1);
    localparam int CW     = (CW_RAW > 10) ? CW_RAW : 10;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(WAIT_MAX);
    localparam logic [1:0]    LAT_LOAD   = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_READ,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t        state_q, state_d;
    logic [S-1:0]  addr_a_q, addr_a_d;
    logic [S-1:0]  addr_b_q, addr_b_d;
    logic [S-1:0]  out_addr_q, out_addr_d;
    logic [T-1:0]  type_q, type_d;
    logic          unary_q, unary_d;
    logic [K-1:0]  label_a_q, label_a_d;
    logic [K-1:0]  label_b_q, label_b_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]    lat_cnt_q, lat_cnt_d;
    logic          dep_hang_q, dep_hang_d;
    logic          deps_ok;

    assign deps_ok = rd_data_ready_0 & (rd_data_ready_1 | unary_q);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            out_addr_q <= '0;
            type_q     <= '0;
            unary_q    <= 1'b0;
            label_a_q  <= '0;
            label_b_q  <= '0;
            wait_cnt_q <= '0;
            lat_cnt_q  <= '0;
            dep_hang_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            out_addr_q <= out_addr_d;
            type_q     <= type_d;
            unary_q    <= unary_d;
            label_a_q  <= label_a_d;
            label_b_q  <= label_b_d;
            wait_cnt_q <= wait_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            dep_hang_q <= dep_hang_d;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (gate_valid)        state_d = ST_CHECK;
                ST_CHECK: if (deps_ok)           state_d = ST_READ;
                ST_READ:  if (!stall_rd)         state_d = ST_WAIT;
                ST_WAIT:  if (lat_cnt_q == 2'd0) state_d = ST_OUT;
                ST_OUT:   if (op_ready)          state_d = ST_IDLE;
                default:                         state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        gate_ready = (state_q == ST_IDLE);
        rd_req_0   = (state_q == ST_READ);
        rd_req_1   = (state_q == ST_READ) & ~unary_q;
        op_valid   = (state_q == ST_OUT);
        rd_addr_0  = addr_a_q;
        rd_addr_1  = unary_q ? addr_a_q : addr_b_q;
    end

    always_comb begin
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        out_addr_d = out_addr_q;
        type_d     = type_q;
        unary_d    = unary_q;
        label_a_d  = label_a_q;
        label_b_d  = label_b_q;
        wait_cnt_d = wait_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        dep_hang_d = dep_hang_q;
        if (clr) begin
            addr_a_d   = '0;
            addr_b_d   = '0;
            out_addr_d = '0;
            type_d     = '0;
            unary_d    = 1'b0;
            label_a_d  = '0;
            label_b_d  = '0;
            wait_cnt_d = '0;
            lat_cnt_d  = '0;
            dep_hang_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gate_valid) begin
                        addr_a_d   = gate_addr_a;
                        addr_b_d   = gate_addr_b;
                        out_addr_d = gate_out_addr;
                        type_d     = gate_type;
                        unary_d    = gate_unary;
                    end
                end
                ST_CHECK: begin
                    if (deps_ok) begin
                        wait_cnt_d = '0;
                    end else begin
                        // Saturate rather than wrap so a long hang never looks fresh again.
                        if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
                        if (wait_cnt_d >= WAIT_LIMIT) dep_hang_d = 1'b1;
                    end
                end
                ST_READ: begin
                    if (!stall_rd) lat_cnt_d = LAT_LOAD;
                end
                ST_WAIT: begin
                    if (lat_cnt_q == 2'd0) begin
                        label_a_d = rd_data_0;
                        label_b_d = unary_q ? '0 : rd_data_1;
                    end else begin
                        lat_cnt_d = lat_cnt_q - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign op_label_a  = label_a_q;
    assign op_label_b  = label_b_q;
    assign op_out_addr = out_addr_q;
    assign op_type     = type_q;
    assign op_unary    = unary_q;
    assign dep_hang    = dep_hang_q;

endmodule

// File: tb/tb_gc_operand_fetch.sv
// Self-checking bench for gc_operand_fetch: a behavioural label RAM plus a per-gate
// latency/label model derived from the fetch protocol.
module tb_gc_operand_fetch;

    localparam int S = 13;
    localparam int K = 128;
    localparam int T = 2;
    localparam int WMAX = 15;

    logic         clk, rst_n, clr;
    logic         gate_valid, gate_ready, gate_unary;
    logic [S-1:0] gate_addr_a, gate_addr_b, gate_out_addr;
    logic [T-1:0] gate_type;
    logic         rd_req_0, rd_req_1;
    logic [S-1:0] rd_addr_0, rd_addr_1;
    logic         rd_data_ready_0, rd_data_ready_1, stall_rd;
    logic [K-1:0] rd_data_0, rd_data_1;
    logic         op_valid, op_ready, op_unary, dep_hang;
    logic [K-1:0] op_label_a, op_label_b;
    logic [S-1:0] op_out_addr;
    logic [T-1:0] op_type;

    int checks   = 0;
    int failures = 0;

    logic [K-1:0] mem [1<<S];
    logic         written [1<<S];

    gc_operand_fetch #(.S(S), .K(K), .T(T), .RD_LAT(1), .WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .gate_valid(gate_valid), .gate_ready(gate_ready),
        .gate_addr_a(gate_addr_a), .gate_addr_b(gate_addr_b), .gate_unary(gate_unary),
        .gate_out_addr(gate_out_addr), .gate_type(gate_type),
        .rd_req_0(rd_req_0), .rd_req_1(rd_req_1),
        .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
        .rd_data_ready_0(rd_data_ready_0), .rd_data_ready_1(rd_data_ready_1),
        .stall_rd(stall_rd), .rd_data_0(rd_data_0), .rd_data_1(rd_data_1),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_label_a(op_label_a), .op_label_b(op_label_b),
        .op_out_addr(op_out_addr), .op_type(op_type), .op_unary(op_unary),
        .dep_hang(dep_hang)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [K-1:0] rnd_label();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // RAM model: written flags are combinational; read data is valid one cycle after an
    // accepted request and is garbage on every other cycle.
    assign rd_data_ready_0 = written[rd_addr_0];
    assign rd_data_ready_1 = written[rd_addr_1];
    always @(posedge clk) begin
        rd_data_0 <= (rd_req_0 && !stall_rd) ? mem[rd_addr_0] : rnd_label();
        rd_data_1 <= (rd_req_1 && !stall_rd) ? mem[rd_addr_1] : rnd_label();
    end

    task automatic check(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One gate end to end. d>0: the dependency flag is written at CHECK cycle d.
    task automatic run_gate(input logic [S-1:0] a, input logic [S-1:0] b, input logic un,
                            input logic [S-1:0] oa, input logic [T-1:0] ty,
                            input logic [K-1:0] da, input logic [K-1:0] db,
                            input int d, input int stalls, input int bp, input string tag);
        logic [S-1:0] dep;
        logic [K-1:0] la, lb;
        int n, n_valid, req0_n, req1_n, stl, exp_lat;
        mem[a] = da;
        written[a] = 1'b1;
        if (!un) begin
            mem[b] = db;
            written[b] = 1'b1;
        end else if (a != b) begin
            written[b] = 1'b0;
        end
        dep = un ? a : b;
        if (d > 0) written[dep] = 1'b0;

        check({tag, ".gate_ready_idle"}, gate_ready, 1);
        gate_valid = 1'b1; gate_addr_a = a; gate_addr_b = b; gate_unary = un;
        gate_out_addr = oa; gate_type = ty;
        @(negedge clk);
        gate_valid = 1'b0; gate_addr_a = S'($urandom); gate_addr_b = S'($urandom);
        gate_unary = ~un; gate_out_addr = ~oa; gate_type = ~ty;

        n = 1; n_valid = 0; req0_n = 0; req1_n = 0; stl = stalls;
        while (n_valid == 0 && n < 200) begin
            if (rd_req_0) begin
                req0_n++;
                check({tag, ".rd_addr_0"}, rd_addr_0, a);
                check({tag, ".rd_addr_1"}, rd_addr_1, un ? a : b);
            end
            if (rd_req_1) req1_n++;
            if (d > 0 && n <= d) check({tag, ".no_req_while_dep"}, rd_req_0, 0);
            if (n == d) begin
                mem[dep] = ~(un ? da : db);
                written[dep] = 1'b1;
            end
            stall_rd = rd_req_0 && (stl > 0);
            if (stall_rd) stl--;
            if (op_valid) n_valid = n;
            else begin
                @(negedge clk);
                n++;
            end
        end
        stall_rd = 1'b0;
        if (n_valid == 0) begin
            check({tag, ".op_valid_timeout"}, 0, 1);
            return;
        end

        exp_lat = ((d > 0) ? d : 1) + 3 + stalls;
        la = mem[a];
        lb = un ? '0 : mem[b];
        check({tag, ".latency"}, n_valid, exp_lat);
        check({tag, ".req0_cycles"}, req0_n, stalls + 1);
        check({tag, ".req1_cycles"}, req1_n, un ? 0 : stalls + 1);
        check({tag, ".label_a"}, op_label_a, la);
        check({tag, ".label_b"}, op_label_b, lb);
        check({tag, ".out_addr"}, op_out_addr, oa);
        check({tag, ".type"}, op_type, ty);
        check({tag, ".unary"}, op_unary, un);
        check({tag, ".gate_ready_out"}, gate_ready, 0);
        check({tag, ".dep_hang"}, dep_hang, 0);

        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check({tag, ".bp_valid"}, op_valid, 1);
            check({tag, ".bp_label_a"}, op_label_a, la);
            check({tag, ".bp_label_b"}, op_label_b, lb);
            check({tag, ".bp_out_addr"}, op_out_addr, oa);
            check({tag, ".bp_gate_ready"}, gate_ready, 0);
        end
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        check({tag, ".valid_drop"}, op_valid, 0);
        check({tag, ".back_idle"}, gate_ready, 1);
    endtask

    initial begin
        logic [K-1:0] pat_a, pat_b;
        rst_n = 1'b0; clr = 1'b0; gate_valid = 1'b0; gate_unary = 1'b0;
        gate_addr_a = '0; gate_addr_b = '0; gate_out_addr = '0; gate_type = '0;
        stall_rd = 1'b0; op_ready = 1'b0;
        for (int i = 0; i < (1 << S); i++) begin
            mem[i] = '0;
            written[i] = 1'b0;
        end

        @(negedge clk);
        @(negedge clk);
        check("reset.gate_ready", gate_ready, 1);
        check("reset.op_valid", op_valid, 0);
        check("reset.rd_req", {rd_req_0, rd_req_1}, 0);
        check("reset.labels", op_label_a | op_label_b, 0);
        check("reset.desc", {op_out_addr, op_type, op_unary}, 0);
        check("reset.dep_hang", dep_hang, 0);
        rst_n = 1'b1;
        @(negedge clk);

        pat_a = {16{8'hAA}};
        pat_b = {16{8'hBB}};
        run_gate(13'd5, 13'd9, 1'b0, 13'd1234, 2'd2, pat_a, pat_b, 0, 0, 0, "ready");
        run_gate(13'd17, 13'd18, 1'b0, 13'd42, 2'd1, rnd_label(), rnd_label(), 10, 0, 0, "dep");
        run_gate(13'd33, 13'd34, 1'b0, 13'd7, 2'd3, rnd_label(), rnd_label(), 0, 3, 0, "stall");
        run_gate(13'd0, 13'd77, 1'b1, 13'd8, 2'd0, rnd_label(), rnd_label(), 0, 0, 0, "unary");
        run_gate(13'd8191, 13'd8191, 1'b0, 13'd8191, 2'd3, rnd_label(), rnd_label(), 0, 0, 0, "equal");
        run_gate(13'd60, 13'd61, 1'b0, 13'd99, 2'd1, rnd_label(), rnd_label(), 0, 0, 10, "bp");

        // Dependency never satisfied: the hang flag rises after WMAX wait cycles and sticks.
        written[13'd200] = 1'b1;
        written[13'd100] = 1'b0;
        gate_valid = 1'b1; gate_addr_a = 13'd200; gate_addr_b = 13'd100; gate_unary = 1'b0;
        @(negedge clk);
        gate_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (n == WMAX) check("hang.before_limit", dep_hang, 0);
            if (n == WMAX + 1) check("hang.at_limit", dep_hang, 1);
            if (n == 20) begin
                check("hang.sticky", dep_hang, 1);
                check("hang.still_waiting", {rd_req_0, op_valid, gate_ready}, 0);
            end
            @(negedge clk);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr.gate_ready", gate_ready, 1);
        check("clr.dep_hang", dep_hang, 0);
        check("clr.op_valid", op_valid, 0);
        check("clr.labels", op_label_a | op_label_b, 0);

        // Reset during WAIT abandons the gate; the next gate must see fresh data.
        run_gate(13'd300, 13'd301, 1'b0, 13'd5, 2'd2, rnd_label(), rnd_label(), 0, 0, 0, "pre_rst");
        gate_valid = 1'b1; gate_addr_a = 13'd310; gate_addr_b = 13'd311; gate_unary = 1'b0;
        gate_out_addr = 13'd55; gate_type = 2'd1;
        mem[13'd310] = rnd_label(); mem[13'd311] = rnd_label();
        written[13'd310] = 1'b1; written[13'd311] = 1'b1;
        @(negedge clk);
        gate_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid.in_wait", {rd_req_0, op_valid, gate_ready}, 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid.op_valid", op_valid, 0);
        check("rst_mid.labels", op_label_a | op_label_b, 0);
        check("rst_mid.desc", {op_out_addr, op_type, op_unary}, 0);
        check("rst_mid.rd_req", {rd_req_0, rd_req_1}, 0);
        check("rst_mid.dep_hang", dep_hang, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid.still_idle", {op_valid, op_label_a != '0}, 0);
        run_gate(13'd320, 13'd321, 1'b0, 13'd66, 2'd3, rnd_label(), rnd_label(), 0, 0, 0, "post_rst");

        for (int g = 0; g < 20; g++) begin
            logic [S-1:0] ra, rb;
            logic         ru;
            ra = S'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? ra : S'($urandom);
            ru = ($urandom_range(0, 3) == 0);
            run_gate(ra, rb, ru, S'($urandom), T'($urandom), rnd_label(), rnd_label(),
                     $urandom_range(0, 8), $urandom_range(0, 3), $urandom_range(0, 3), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
